// File: rtl/combat_resolver.sv
// combat_resolver: per-frame hit arbiter between two fighters.
// Samples hitbox/hurtbox overlaps once per frame tick, resolves hits, blocks
// and trades, and owns stun counters, health, KO and the winner code.
// Ports:
//   clk, rst (sync, active-high), frame_tick, round_reset
//   pN_hit_{x1,x2,y1,y2}, pN_hit_active    attacker hitbox of player N
//   pN_hurt_{x1,x2,y1,y2}, pN_hurt_active  hurtbox of player N
//   pN_block                               player N holding guard
//   pN_hit_pulse, pN_block_pulse           one-cycle event pulses
//   pN_stunned, pN_health                  stun level and health
//   trade_pulse, ko, winner                round outcome
module combat_resolver #(
  parameter int unsigned HEALTH_INIT      = 100,
  parameter int unsigned DAMAGE_HIT       = 10,
  parameter int unsigned HITSTUN_FRAMES   = 12,
  parameter int unsigned BLOCKSTUN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       round_reset,
  input  logic [9:0] p1_hit_x1,
  input  logic [9:0] p1_hit_x2,
  input  logic [9:0] p1_hit_y1,
  input  logic [9:0] p1_hit_y2,
  input  logic       p1_hit_active,
  input  logic [9:0] p1_hurt_x1,
  input  logic [9:0] p1_hurt_x2,
  input  logic [9:0] p1_hurt_y1,
  input  logic [9:0] p1_hurt_y2,
  input  logic       p1_hurt_active,
  input  logic       p1_block,
  input  logic [9:0] p2_hit_x1,
  input  logic [9:0] p2_hit_x2,
  input  logic [9:0] p2_hit_y1,
  input  logic [9:0] p2_hit_y2,
  input  logic       p2_hit_active,
  input  logic [9:0] p2_hurt_x1,
  input  logic [9:0] p2_hurt_x2,
  input  logic [9:0] p2_hurt_y1,
  input  logic [9:0] p2_hurt_y2,
  input  logic       p2_hurt_active,
  input  logic       p2_block,
  output logic       p1_hit_pulse,
  output logic       p1_block_pulse,
  output logic       p1_stunned,
  output logic [7:0] p1_health,
  output logic       p2_hit_pulse,
  output logic       p2_block_pulse,
  output logic       p2_stunned,
  output logic [7:0] p2_health,
  output logic       trade_pulse,
  output logic       ko,
  output logic [1:0] winner
);

  localparam int unsigned CW = 10;
  localparam int unsigned HW = 8;
  localparam int unsigned SW = 6;

  localparam logic [HW-1:0] HEALTH_RST = HW'(HEALTH_INIT);
  localparam logic [HW-1:0] DAMAGE     = HW'(DAMAGE_HIT);
  localparam logic [SW-1:0] HITSTUN    = SW'(HITSTUN_FRAMES);
  localparam logic [SW-1:0] BLOCKSTUN  = SW'(BLOCKSTUN_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_RESOLVE, S_GAME_OVER} state_t;

  state_t        state_q, state_d;
  logic          ov_a_q, ov_a_d, ov_b_q, ov_b_d;
  logic          latch1_q, latch1_d, latch2_q, latch2_d;
  logic [SW-1:0] stun1_q, stun1_d, stun2_q, stun2_d;
  logic          hs1_q, hs1_d, hs2_q, hs2_d;
  logic [HW-1:0] health1_q, health1_d, health2_q, health2_d;
  logic          p1_hit_q, p1_hit_d, p2_hit_q, p2_hit_d;
  logic          p1_blk_q, p1_blk_d, p2_blk_q, p2_blk_d;
  logic          trade_q, trade_d;
  logic          stunned1_q, stunned1_d, stunned2_q, stunned2_d;
  logic          ko_q, ko_d;
  logic [1:0]    winner_q, winner_d;
  logic          land_a, land_b;

  // Strict-inequality box overlap; a box with x1>=x2 or y1>=y2 (e.g. a
  // mirrored box whose coordinate wrapped) never overlaps anything.
  function automatic logic boxes_overlap(
    input logic act_a, input logic [CW-1:0] ax1, input logic [CW-1:0] ax2,
    input logic [CW-1:0] ay1, input logic [CW-1:0] ay2,
    input logic act_b, input logic [CW-1:0] bx1, input logic [CW-1:0] bx2,
    input logic [CW-1:0] by1, input logic [CW-1:0] by2);
    boxes_overlap = act_a && act_b &&
                    (ax1 < ax2) && (ay1 < ay2) && (bx1 < bx2) && (by1 < by2) &&
                    (ax1 < bx2) && (bx1 < ax2) && (ay1 < by2) && (by1 < ay2);
  endfunction

  function automatic logic [HW-1:0] take_damage(input logic [HW-1:0] h);
    take_damage = (h > DAMAGE) ? HW'(h - DAMAGE) : '0;
  endfunction

  // Next-state and event resolution
  always_comb begin
    state_d    = state_q;
    ov_a_d     = ov_a_q;
    ov_b_d     = ov_b_q;
    latch1_d   = latch1_q;
    latch2_d   = latch2_q;
    stun1_d    = stun1_q;
    stun2_d    = stun2_q;
    hs1_d      = hs1_q;
    hs2_d      = hs2_q;
    health1_d  = health1_q;
    health2_d  = health2_q;
    p1_hit_d   = 1'b0;
    p2_hit_d   = 1'b0;
    p1_blk_d   = 1'b0;
    p2_blk_d   = 1'b0;
    trade_d    = 1'b0;
    ko_d       = ko_q;
    winner_d   = winner_q;
    // ov_a: p1 attacks p2; ov_b: p2 attacks p1
    land_a     = ov_a_q && !latch1_q;
    land_b     = ov_b_q && !latch2_q;

    unique case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          state_d = S_SAMPLE;
          if (stun1_q != '0) stun1_d = stun1_q - SW'(1);
          if (stun2_q != '0) stun2_d = stun2_q - SW'(1);
        end
      end
      S_SAMPLE: begin
        ov_a_d = boxes_overlap(p1_hit_active, p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2,
                               p2_hurt_active, p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2);
        ov_b_d = boxes_overlap(p2_hit_active, p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2,
                               p1_hurt_active, p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2);
        state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        // Guard is unavailable while the defender is still in hitstun
        if (land_a) begin
          latch1_d = 1'b1;
          if (p2_block && !(stun2_q != '0 && hs2_q)) begin
            p2_blk_d = 1'b1;
            stun2_d  = BLOCKSTUN;
            hs2_d    = 1'b0;
          end else begin
            p2_hit_d  = 1'b1;
            stun2_d   = HITSTUN;
            hs2_d     = 1'b1;
            health2_d = take_damage(health2_q);
          end
        end
        if (land_b) begin
          latch2_d = 1'b1;
          if (p1_block && !(stun1_q != '0 && hs1_q)) begin
            p1_blk_d = 1'b1;
            stun1_d  = BLOCKSTUN;
            hs1_d    = 1'b0;
          end else begin
            p1_hit_d  = 1'b1;
            stun1_d   = HITSTUN;
            hs1_d     = 1'b1;
            health1_d = take_damage(health1_q);
          end
        end
        trade_d = p1_hit_d && p2_hit_d;
        if (health1_d == '0 || health2_d == '0) begin
          ko_d     = 1'b1;
          winner_d = {health1_d == '0, health2_d == '0};
          state_d  = S_GAME_OVER;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAME_OVER: state_d = S_GAME_OVER;
      default:     state_d = S_IDLE;
    endcase

    // A released hitbox ends the attack instance, re-arming its connect latch
    if (!p1_hit_active) latch1_d = 1'b0;
    if (!p2_hit_active) latch2_d = 1'b0;

    if (round_reset) begin
      state_d   = S_IDLE;
      ov_a_d    = 1'b0;
      ov_b_d    = 1'b0;
      latch1_d  = 1'b0;
      latch2_d  = 1'b0;
      stun1_d   = '0;
      stun2_d   = '0;
      hs1_d     = 1'b0;
      hs2_d     = 1'b0;
      health1_d = HEALTH_RST;
      health2_d = HEALTH_RST;
      p1_hit_d  = 1'b0;
      p2_hit_d  = 1'b0;
      p1_blk_d  = 1'b0;
      p2_blk_d  = 1'b0;
      trade_d   = 1'b0;
      ko_d      = 1'b0;
      winner_d  = 2'b00;
    end

    stunned1_d = (stun1_d != '0);
    stunned2_d = (stun2_d != '0);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ov_a_q     <= 1'b0;
      ov_b_q     <= 1'b0;
      latch1_q   <= 1'b0;
      latch2_q   <= 1'b0;
      stun1_q    <= '0;
      stun2_q    <= '0;
      hs1_q      <= 1'b0;
      hs2_q      <= 1'b0;
      health1_q  <= HEALTH_RST;
      health2_q  <= HEALTH_RST;
      p1_hit_q   <= 1'b0;
      p2_hit_q   <= 1'b0;
      p1_blk_q   <= 1'b0;
      p2_blk_q   <= 1'b0;
      trade_q    <= 1'b0;
      stunned1_q <= 1'b0;
      stunned2_q <= 1'b0;
      ko_q       <= 1'b0;
      winner_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      ov_a_q     <= ov_a_d;
      ov_b_q     <= ov_b_d;
      latch1_q   <= latch1_d;
      latch2_q   <= latch2_d;
      stun1_q    <= stun1_d;
      stun2_q    <= stun2_d;
      hs1_q      <= hs1_d;
      hs2_q      <= hs2_d;
      health1_q  <= health1_d;
      health2_q  <= health2_d;
      p1_hit_q   <= p1_hit_d;
      p2_hit_q   <= p2_hit_d;
      p1_blk_q   <= p1_blk_d;
      p2_blk_q   <= p2_blk_d;
      trade_q    <= trade_d;
      stunned1_q <= stunned1_d;
      stunned2_q <= stunned2_d;
      ko_q       <= ko_d;
      winner_q   <= winner_d;
    end
  end

  assign p1_hit_pulse   = p1_hit_q;
  assign p1_block_pulse = p1_blk_q;
  assign p1_stunned     = stunned1_q;
  assign p1_health      = health1_q;
  assign p2_hit_pulse   = p2_hit_q;
  assign p2_block_pulse = p2_blk_q;
  assign p2_stunned     = stunned2_q;
  assign p2_health      = health2_q;
  assign trade_pulse    = trade_q;
  assign ko             = ko_q;
  assign winner         = winner_q;

endmodule

// File: tb/tb_combat_resolver.sv
// Directed bench for combat_resolver: latency, connect latch, block,
// hitstun guard lockout, trade, edge touching, wrapped boxes, KO and round reset.
module tb_combat_resolver;

  logic       clk = 1'b0;
  logic       rst, frame_tick, round_reset;
  logic [9:0] p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2;
  logic [9:0] p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2;
  logic [9:0] p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2;
  logic [9:0] p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2;
  logic       p1_hit_active, p1_hurt_active, p1_block;
  logic       p2_hit_active, p2_hurt_active, p2_block;
  logic       p1_hit_pulse, p1_block_pulse, p1_stunned;
  logic       p2_hit_pulse, p2_block_pulse, p2_stunned;
  logic [7:0] p1_health, p2_health;
  logic       trade_pulse, ko;
  logic [1:0] winner;
  logic [4:0] pulses;

  int n_checks = 0;
  int n_pass   = 0;

  // {p1_hit, p2_hit, p1_block, p2_block, trade}
  assign pulses = {p1_hit_pulse, p2_hit_pulse, p1_block_pulse, p2_block_pulse, trade_pulse};

  always #5 clk = ~clk;

  combat_resolver dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .round_reset(round_reset),
    .p1_hit_x1(p1_hit_x1), .p1_hit_x2(p1_hit_x2), .p1_hit_y1(p1_hit_y1), .p1_hit_y2(p1_hit_y2),
    .p1_hit_active(p1_hit_active),
    .p1_hurt_x1(p1_hurt_x1), .p1_hurt_x2(p1_hurt_x2), .p1_hurt_y1(p1_hurt_y1), .p1_hurt_y2(p1_hurt_y2),
    .p1_hurt_active(p1_hurt_active), .p1_block(p1_block),
    .p2_hit_x1(p2_hit_x1), .p2_hit_x2(p2_hit_x2), .p2_hit_y1(p2_hit_y1), .p2_hit_y2(p2_hit_y2),
    .p2_hit_active(p2_hit_active),
    .p2_hurt_x1(p2_hurt_x1), .p2_hurt_x2(p2_hurt_x2), .p2_hurt_y1(p2_hurt_y1), .p2_hurt_y2(p2_hurt_y2),
    .p2_hurt_active(p2_hurt_active), .p2_block(p2_block),
    .p1_hit_pulse(p1_hit_pulse), .p1_block_pulse(p1_block_pulse), .p1_stunned(p1_stunned),
    .p1_health(p1_health),
    .p2_hit_pulse(p2_hit_pulse), .p2_block_pulse(p2_block_pulse), .p2_stunned(p2_stunned),
    .p2_health(p2_health),
    .trade_pulse(trade_pulse), .ko(ko), .winner(winner)
  );

  // Tick for one cycle k and return #1 into cycle k+3, where results are visible
  task automatic run_frame();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic rearm_p1();
    @(posedge clk); #1 p1_hit_active = 1'b0;
    @(posedge clk); #1 p1_hit_active = 1'b1;
  endtask

  task automatic pulse_round_reset();
    @(posedge clk); #1 round_reset = 1'b1;
    @(posedge clk); #1 round_reset = 1'b0;
  endtask

  task automatic default_boxes();
    p1_hit_x1 = 10'd100; p1_hit_x2 = 10'd200; p1_hit_y1 = 10'd100; p1_hit_y2 = 10'd200;
    p2_hurt_x1 = 10'd150; p2_hurt_x2 = 10'd250; p2_hurt_y1 = 10'd50; p2_hurt_y2 = 10'd150;
    p1_hurt_x1 = 10'd0; p1_hurt_x2 = 10'd50; p1_hurt_y1 = 10'd0; p1_hurt_y2 = 10'd50;
    p2_hit_x1 = 10'd40; p2_hit_x2 = 10'd60; p2_hit_y1 = 10'd40; p2_hit_y2 = 10'd60;
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_tick = 1'b0; round_reset = 1'b0;
    p1_hit_active = 1'b0; p2_hit_active = 1'b0;
    p1_hurt_active = 1'b1; p2_hurt_active = 1'b1;
    p1_block = 1'b0; p2_block = 1'b0;
    default_boxes();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if ({pulses, p1_stunned, p2_stunned, ko, winner} !== 10'b0 || p1_health !== 8'd100 || p2_health !== 8'd100)
      $display("FAIL reset: pulses=%b stun=%b%b ko=%b win=%b h1=%0d h2=%0d, want all 0 and health 100",
               pulses, p1_stunned, p2_stunned, ko, winner, p1_health, p2_health);
    else n_pass++;
  endtask

  task automatic test_hit_latency();
    p1_hit_active = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    n_checks++;
    if (pulses !== 5'b0) $display("FAIL latency_k1: pulses=%b want 00000", pulses); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (pulses !== 5'b0) $display("FAIL latency_k2: pulses=%b want 00000", pulses); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (pulses !== 5'b01000 || p2_health !== 8'd90 || p2_stunned !== 1'b1 || p1_health !== 8'd100)
      $display("FAIL first_hit: pulses=%b h2=%0d stun2=%b h1=%0d want 01000 90 1 100",
               pulses, p2_health, p2_stunned, p1_health);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (pulses !== 5'b0 || p2_health !== 8'd90)
      $display("FAIL pulse_width: pulses=%b h2=%0d want 00000 90", pulses, p2_health);
    else n_pass++;
  endtask

  task automatic test_connect_latch();
    for (int i = 0; i < 5; i++) begin
      run_frame();
      n_checks++;
      if (pulses !== 5'b0 || p2_health !== 8'd90)
        $display("FAIL latch_hold%0d: pulses=%b h2=%0d want 00000 90", i, pulses, p2_health);
      else n_pass++;
    end
    rearm_p1();
    run_frame();
    n_checks++;
    if (pulses !== 5'b01000 || p2_health !== 8'd80)
      $display("FAIL latch_rearm: pulses=%b h2=%0d want 01000 80", pulses, p2_health);
    else n_pass++;
  endtask

  task automatic test_block();
    p2_block = 1'b1;
    pulse_round_reset();
    n_checks++;
    if (p2_health !== 8'd100 || p2_stunned !== 1'b0)
      $display("FAIL round_reset1: h2=%0d stun2=%b want 100 0", p2_health, p2_stunned);
    else n_pass++;
    run_frame();
    n_checks++;
    if (pulses !== 5'b00010 || p2_health !== 8'd100 || p2_stunned !== 1'b1)
      $display("FAIL block: pulses=%b h2=%0d stun2=%b want 00010 100 1", pulses, p2_health, p2_stunned);
    else n_pass++;
    repeat (7) run_frame();
    n_checks++;
    if (p2_stunned !== 1'b1 || pulses !== 5'b0)
      $display("FAIL blockstun_7: stun2=%b pulses=%b want 1 00000", p2_stunned, pulses);
    else n_pass++;
    run_frame();
    n_checks++;
    if (p2_stunned !== 1'b0)
      $display("FAIL blockstun_8: stun2=%b want 0", p2_stunned);
    else n_pass++;
  endtask

  task automatic test_hitstun_no_guard();
    p2_block = 1'b0;
    pulse_round_reset();
    run_frame();
    rearm_p1();
    p2_block = 1'b1;
    run_frame();
    n_checks++;
    if (pulses !== 5'b01000 || p2_health !== 8'd80)
      $display("FAIL hitstun_guard: pulses=%b h2=%0d want 01000 80", pulses, p2_health);
    else n_pass++;
    p2_block = 1'b0;
  endtask

  task automatic test_trade_and_touch();
    p2_hit_active = 1'b1;
    pulse_round_reset();
    run_frame();
    n_checks++;
    if (pulses !== 5'b11001 || p1_health !== 8'd90 || p2_health !== 8'd90)
      $display("FAIL trade: pulses=%b h1=%0d h2=%0d want 11001 90 90", pulses, p1_health, p2_health);
    else n_pass++;
    p1_hit_active = 1'b0;
    p2_hit_x1 = 10'd50; p2_hit_x2 = 10'd60;
    pulse_round_reset();
    run_frame();
    n_checks++;
    if (pulses !== 5'b0 || p1_health !== 8'd100 || p2_health !== 8'd100)
      $display("FAIL touch_edge: pulses=%b h1=%0d h2=%0d want 00000 100 100", pulses, p1_health, p2_health);
    else n_pass++;
    p2_hit_active = 1'b0;
    default_boxes();
  endtask

  task automatic test_wrap_ignored_ticks();
    p1_hit_active = 1'b1;
    pulse_round_reset();
    run_frame();
    p1_hit_x1 = 10'd1000; p1_hit_x2 = 10'd20;
    p2_hurt_x1 = 10'd10; p2_hurt_x2 = 10'd1010;
    rearm_p1();
    // Tick held through SAMPLE and RESOLVE: only the first cycle is accepted
    @(posedge clk); #1 frame_tick = 1'b1;
    repeat (3) @(posedge clk);
    #1 frame_tick = 1'b0;
    n_checks++;
    if (pulses !== 5'b0 || p2_health !== 8'd90)
      $display("FAIL wrap_box: pulses=%b h2=%0d want 00000 90", pulses, p2_health);
    else n_pass++;
    repeat (10) run_frame();
    n_checks++;
    if (p2_stunned !== 1'b1)
      $display("FAIL ignored_ticks: stun2=%b want 1", p2_stunned);
    else n_pass++;
    run_frame();
    n_checks++;
    if (p2_stunned !== 1'b0)
      $display("FAIL stun_expire: stun2=%b want 0", p2_stunned);
    else n_pass++;
    default_boxes();
  endtask

  task automatic test_ko();
    pulse_round_reset();
    for (int i = 0; i < 10; i++) begin
      rearm_p1();
      run_frame();
      if (i == 8) begin
        n_checks++;
        if (p2_health !== 8'd10 || ko !== 1'b0)
          $display("FAIL pre_ko: h2=%0d ko=%b want 10 0", p2_health, ko);
        else n_pass++;
      end
    end
    n_checks++;
    if (pulses !== 5'b01000 || p2_health !== 8'd0 || ko !== 1'b1 || winner !== 2'b01)
      $display("FAIL ko: pulses=%b h2=%0d ko=%b win=%b want 01000 0 1 01", pulses, p2_health, ko, winner);
    else n_pass++;
    rearm_p1();
    run_frame();
    n_checks++;
    if (pulses !== 5'b0 || p2_health !== 8'd0 || ko !== 1'b1 || winner !== 2'b01)
      $display("FAIL game_over: pulses=%b h2=%0d ko=%b win=%b want 00000 0 1 01", pulses, p2_health, ko, winner);
    else n_pass++;
    pulse_round_reset();
    n_checks++;
    if (p2_health !== 8'd100 || ko !== 1'b0 || winner !== 2'b00 || p2_stunned !== 1'b0)
      $display("FAIL round_reset2: h2=%0d ko=%b win=%b stun2=%b want 100 0 00 0",
               p2_health, ko, winner, p2_stunned);
    else n_pass++;
    rearm_p1();
    run_frame();
    n_checks++;
    if (pulses !== 5'b01000 || p2_health !== 8'd90)
      $display("FAIL after_round: pulses=%b h2=%0d want 01000 90", pulses, p2_health);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_hit_latency();
    test_connect_latch();
    test_block();
    test_hitstun_no_guard();
    test_trade_and_touch();
    test_wrap_ignored_ticks();
    test_ko();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
